dstack_spill: RTL and testbench

DSTACK_SPILL -- requirements
Module: dstack_spill

---
 rtl/dstack_spill.sv | 71 +++++++
 tb/tb_dstack_spill.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dstack_spill.sv
// dstack_spill: on-chip data stack spill/fill to memory; DSTACK_SPILL_FAULT_EN adds underflow/exhaustion fault pulses
module dstack_spill #(
    parameter int DEPTH_MAG  = 7,
    parameter int WIDTH      = 32,
    parameter int SPILL_MAG  = 10,
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int HIGH_MARK  = 120,
    parameter int LOW_MARK   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            movement,
    input  logic [WIDTH-1:0]      bottom_val,
    output logic                  stall,
    output logic                  spill_drop,
    output logic                  fill_push,
    output logic [WIDTH-1:0]      fill_val,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ack,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  fault
);
    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;
    localparam logic [SPILL_MAG:0]   FULL = {1'b1, {SPILL_MAG{1'b0}}};
    localparam logic [DEPTH_MAG-1:0] HI   = DEPTH_MAG'(HIGH_MARK);
    localparam logic [DEPTH_MAG-1:0] LO   = DEPTH_MAG'(LOW_MARK);
    state_t               state;
    logic [DEPTH_MAG-1:0] depth, depth_mv;
    logic [SPILL_MAG:0]   spill_cnt;
    logic [1:0]           mv, dec;
    assign stall      = state != IDLE;
    assign mv         = stall ? 2'b00 : movement;
    assign dec        = mv[1] ? (mv[0] ? 2'd2 : 2'd1) : 2'd0;
    assign depth_mv   = depth + DEPTH_MAG'(mv == 2'b01) - DEPTH_MAG'(dec);
    assign spill_drop = !reset && state == SPILL && mem_ack;
    assign fill_push  = !reset && state == FILL && mem_ack;
    assign fill_val   = fill_push ? mem_rdata : '0;
    assign mem_req    = stall;
    assign mem_we     = state == SPILL;
    assign mem_addr   = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(spill_cnt) - ADDR_WIDTH'(state == FILL);
    assign mem_wdata  = bottom_val;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            depth     <= '0;
            spill_cnt <= '0;
        end else begin
            depth     <= depth_mv - DEPTH_MAG'(spill_drop) + DEPTH_MAG'(fill_push);
            spill_cnt <= spill_cnt + (SPILL_MAG+1)'(spill_drop) - (SPILL_MAG+1)'(fill_push);
            state     <= state == IDLE ? (depth_mv >= HI && spill_cnt < FULL ? SPILL :
                                          depth_mv < LO && spill_cnt != '0 ? FILL : IDLE)
                                       : (mem_ack ? IDLE : state);
        end
    end
`ifdef DSTACK_SPILL_FAULT_EN
    localparam int AW = DEPTH_MAG + SPILL_MAG + 1;
    logic [AW-1:0] avail;
    logic          fault_q;
    assign avail = AW'(depth) + AW'(spill_cnt);
    assign fault = fault_q;
    always_ff @(posedge clk) begin
        fault_q <= !reset && ((AW'(dec) > avail) || (mv == 2'b01 && depth >= HI && spill_cnt == FULL));
    end
`else
    assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_dstack_spill.sv
// tb_dstack_spill: directed spill/fill/reset/fault checks against hand-computed values
module tb_dstack_spill;
    logic        clk = 0;
    logic        reset = 1;
    logic [1:0]  movement = 0;
    logic [31:0] bottom_val = 32'h1111_1111;
    logic        stall, spill_drop, fill_push, mem_req, mem_we, mem_ack = 0, fault;
    logic [31:0] fill_val, mem_wdata, mem_rdata = 0;
    logic [15:0] mem_addr;
    int          tests = 0, fails = 0;
    logic        fexp;
    always #5 clk = ~clk;
    dstack_spill dut (
        .clk(clk), .reset(reset), .movement(movement), .bottom_val(bottom_val),
        .stall(stall), .spill_drop(spill_drop), .fill_push(fill_push), .fill_val(fill_val),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fault(fault)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    initial begin
`ifdef DSTACK_SPILL_FAULT_EN
        fexp = 1'b1;
`else
        fexp = 1'b0;
`endif
        cyc();
        reset = 0;
        #2;
        check("rst_stall", stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_drop", spill_drop, 0);
        check("rst_fpush", fill_push, 0);
        check("rst_fault", fault, 0);
        check("rst_fval", fill_val, 0);
        movement = 2'b01;
        repeat (120) cyc();
        movement = 0;
        #2;
        check("sp_stall", stall, 1);
        check("sp_req", mem_req, 1);
        check("sp_we", mem_we, 1);
        check("sp_addr", mem_addr, 0);
        check("sp_wdata", mem_wdata, 32'h1111_1111);
        check("sp_nodrop", spill_drop, 0);
        cyc();
        mem_ack = 1;
        #2;
        check("sp_drop", spill_drop, 1);
        cyc();
        mem_ack = 0;
        #2;
        check("sp_done_stall", stall, 0);
        check("sp_done_drop", spill_drop, 0);
        movement = 2'b10;
        repeat (111) cyc();
        movement = 0;
        #2;
        check("d8_nofill", stall, 0);
        movement = 2'b10;
        cyc();
        movement = 0;
        #2;
        check("fl_stall", stall, 1);
        check("fl_req", mem_req, 1);
        check("fl_we", mem_we, 0);
        check("fl_addr", mem_addr, 0);
        cyc();
        mem_ack = 1;
        mem_rdata = 32'hDEAD_BEEF;
        #2;
        check("fl_push", fill_push, 1);
        check("fl_val", fill_val, 32'hDEAD_BEEF);
        cyc();
        mem_ack = 0;
        #2;
        check("fl_done_stall", stall, 0);
        check("fl_done_push", fill_push, 0);
        movement = 2'b10;
        cyc();
        movement = 0;
        #2;
        check("cnt0_nofill", stall, 0);
        movement = 2'b01;
        repeat (113) cyc();
        movement = 0;
        bottom_val = 32'hCAFE_0001;
        #2;
        check("hold_stall0", stall, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            #2;
            check("hold_addr", mem_addr, 0);
            check("hold_wdata", mem_wdata, 32'hCAFE_0001);
            check("hold_stall", stall, 1);
            check("hold_nodrop", spill_drop, 0);
        end
        cyc();
        mem_ack = 1;
        #2;
        check("hold_drop", spill_drop, 1);
        cyc();
        mem_ack = 0;
        #2;
        check("hold_done", stall, 0);
        movement = 2'b10;
        repeat (112) cyc();
        movement = 0;
        #2;
        check("rf_stall", stall, 1);
        check("rf_we", mem_we, 0);
        check("rf_addr", mem_addr, 0);
        cyc();
        reset = 1;
        mem_ack = 1;
        mem_rdata = 32'h1234_5678;
        #2;
        check("rf_nopush", fill_push, 0);
        check("rf_noval", fill_val, 0);
        cyc();
        reset = 0;
        mem_ack = 0;
        #2;
        check("rf_req", mem_req, 0);
        check("rf_stall0", stall, 0);
        check("rf_fval", fill_val, 0);
        movement = 2'b01;
        cyc();
        movement = 2'b10;
        cyc();
        movement = 0;
        #2;
        check("rf_cnt0", stall, 0);
        cyc();
        #2;
        check("rf_cnt0b", stall, 0);
        reset = 1;
        cyc();
        reset = 0;
        movement = 2'b01;
        cyc();
        movement = 2'b11;
        cyc();
        movement = 0;
        #2;
        check("flt_pulse", fault, fexp);
        cyc();
        #2;
        check("flt_clear", fault, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
